data_memory_arbiter: RTL and testbench

Two-port arbiter sharing the single-port `data_memory` (64-bit words, synchronous write on `clk` rising edge, combinational read) between requester 0 (core load/store stage) and requester 1 (loader/debug port). Each accepted request takes one memory cycle. Round-robin arbitration, an optional lock for atomic read-modify-write sequences, and a bounded lock timeout. Sits directly in front of `data_memory`; the memory side of the arbiter drives the memory ports one-to-one.

---
 rtl/data_memory_arbiter.sv | 131 +++++++++++++
 tb/tb_data_memory_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin arbiter with bounded lock in front of data_memory
module data_memory_arbiter #(
    parameter int WORDSIZE = 64,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid0,
    input  logic                req_write0,
    input  logic                req_lock0,
    input  logic [WORDSIZE-1:0] req_addr0,
    input  logic [WORDSIZE-1:0] req_wdata0,
    input  logic                req_valid1,
    input  logic                req_write1,
    input  logic                req_lock1,
    input  logic [WORDSIZE-1:0] req_addr1,
    input  logic [WORDSIZE-1:0] req_wdata1,
    output logic                req_ready0,
    output logic                req_ready1,
    output logic                resp_valid0,
    output logic [WORDSIZE-1:0] resp_rdata0,
    output logic                resp_valid1,
    output logic [WORDSIZE-1:0] resp_rdata1,
    output logic [WORDSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_data_input,
    output logic                mem_write_en,
    input  logic [WORDSIZE-1:0] mem_data_output
);

    localparam int LCNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } state_t;

    state_t              state, state_next;
    logic                ptr, ptr_next;
    logic [LCNT_W-1:0]   lcnt, lcnt_next;
    logic                grant0, grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB;
            ptr         <= 1'b0;
            lcnt        <= '0;
            resp_valid0 <= 1'b0;
            resp_valid1 <= 1'b0;
            resp_rdata0 <= '0;
            resp_rdata1 <= '0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            lcnt        <= lcnt_next;
            resp_valid0 <= grant0 && !req_write0;
            resp_valid1 <= grant1 && !req_write1;
            if (grant0 && !req_write0)
                resp_rdata0 <= mem_data_output;
            if (grant1 && !req_write1)
                resp_rdata1 <= mem_data_output;
        end
    end

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        ptr_next   = ptr;
        lcnt_next  = lcnt;
        if (!rst) begin
            case (state)
                ARB: begin
                    grant0 = req_valid0 && (!req_valid1 || !ptr);
                    grant1 = req_valid1 && (!req_valid0 || ptr);
                    if (grant0) begin
                        ptr_next = 1'b1;
                        if (req_lock0) begin
                            state_next = LOCKED0;
                            lcnt_next  = LCNT_W'(1);
                        end
                    end
                    if (grant1) begin
                        ptr_next = 1'b0;
                        if (req_lock1) begin
                            state_next = LOCKED1;
                            lcnt_next  = LCNT_W'(1);
                        end
                    end
                end
                LOCKED0: begin
                    lcnt_next = lcnt + 1'b1;
                    // Timeout cycle is a bubble so the other side gets the next ARB slot
                    if (lcnt == LCNT_MAX) begin
                        state_next = ARB;
                        ptr_next   = 1'b1;
                    end else begin
                        grant0 = req_valid0;
                        if (grant0)
                            ptr_next = 1'b1;
                        if (!req_lock0)
                            state_next = ARB;
                    end
                end
                LOCKED1: begin
                    lcnt_next = lcnt + 1'b1;
                    if (lcnt == LCNT_MAX) begin
                        state_next = ARB;
                        ptr_next   = 1'b0;
                    end else begin
                        grant1 = req_valid1;
                        if (grant1)
                            ptr_next = 1'b0;
                        if (!req_lock1)
                            state_next = ARB;
                    end
                end
                default: state_next = ARB;
            endcase
        end
    end

    assign req_ready0 = grant0;
    assign req_ready1 = grant1;

    assign mem_addr       = grant0 ? req_addr0  : (grant1 ? req_addr1  : '0);
    assign mem_data_input = grant0 ? req_wdata0 : (grant1 ? req_wdata1 : '0);
    assign mem_write_en   = (grant0 && req_write0) || (grant1 && req_write1);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - randomized and directed checks of data_memory_arbiter against a reference model
module tb_data_memory_arbiter;

    localparam int W = 64;
    localparam int LOCK_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          v [2];
    logic          w [2];
    logic          l [2];
    logic [W-1:0]  a [2];
    logic [W-1:0]  d [2];
    logic          req_ready0, req_ready1, resp_valid0, resp_valid1, mem_write_en;
    logic [W-1:0]  resp_rdata0, resp_rdata1, mem_addr, mem_data_input, mem_data_output;

    logic [W-1:0]  mem [16];
    logic [W-1:0]  ref_mem [16];

    int            m_owner, m_age, m_turn;
    logic          m_rv [2];
    logic [W-1:0]  m_rd [2];
    int            tests = 0;
    int            failed = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.WORDSIZE(W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(v[0]), .req_write0(w[0]), .req_lock0(l[0]), .req_addr0(a[0]), .req_wdata0(d[0]),
        .req_valid1(v[1]), .req_write1(w[1]), .req_lock1(l[1]), .req_addr1(a[1]), .req_wdata1(d[1]),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .resp_valid0(resp_valid0), .resp_rdata0(resp_rdata0),
        .resp_valid1(resp_valid1), .resp_rdata1(resp_rdata1),
        .mem_addr(mem_addr), .mem_data_input(mem_data_input),
        .mem_write_en(mem_write_en), .mem_data_output(mem_data_output)
    );

    // Environment: the data_memory the arbiter fronts
    assign mem_data_output = mem[mem_addr[3:0]];
    always @(posedge clk)
        if (mem_write_en)
            mem[mem_addr[3:0]] <= mem_data_input;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            v[p] = 1'b0; w[p] = 1'b0; l[p] = 1'b0; a[p] = '0; d[p] = '0;
        end
    endtask

    task automatic set_req(input int p, input logic vv, input logic ww, input logic ll,
                           input logic [W-1:0] aa, input logic [W-1:0] dd);
        v[p] = vv; w[p] = ww; l[p] = ll; a[p] = aa; d[p] = dd;
    endtask

    // Settle, compare the DUT against the model for this cycle, then advance the model
    task automatic eval();
        int g;
        logic [W-1:0] ea, ed;
        logic ew;
        #3;
        g = -1;
        if (!rst) begin
            if (m_owner < 0) begin
                if (v[0] && v[1]) g = m_turn;
                else if (v[0]) g = 0;
                else if (v[1]) g = 1;
            end else if (m_age < LOCK_MAX && v[m_owner]) begin
                g = m_owner;
            end
        end
        ea = '0; ed = '0; ew = 1'b0;
        if (g >= 0) begin
            ea = a[g]; ed = d[g]; ew = w[g];
        end
        chk("ready0", req_ready0, W'(g == 0));
        chk("ready1", req_ready1, W'(g == 1));
        chk("mem_addr", mem_addr, ea);
        chk("mem_data_input", mem_data_input, ed);
        chk("mem_write_en", mem_write_en, W'(ew));
        chk("resp_valid0", resp_valid0, W'(m_rv[0]));
        chk("resp_valid1", resp_valid1, W'(m_rv[1]));
        chk("resp_rdata0", resp_rdata0, m_rd[0]);
        chk("resp_rdata1", resp_rdata1, m_rd[1]);

        if (rst) begin
            m_owner = -1; m_age = 0; m_turn = 0;
            for (int p = 0; p < 2; p++) begin m_rv[p] = 1'b0; m_rd[p] = '0; end
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_rv[p] = (g == p) && !w[p];
                if (m_rv[p]) m_rd[p] = ref_mem[a[p][3:0]];
            end
            if (g >= 0 && w[g]) ref_mem[a[g][3:0]] = d[g];
            if (m_owner < 0) begin
                if (g >= 0) begin
                    m_turn = 1 - g;
                    if (l[g]) begin m_owner = g; m_age = 1; end
                end
            end else if (m_age >= LOCK_MAX) begin
                m_turn = 1 - m_owner;
                m_owner = -1;
            end else begin
                if (g >= 0) m_turn = 1 - g;
                if (!l[m_owner]) m_owner = -1;
                else m_age++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = W'(i * 100 + 7);
            ref_mem[i] = W'(i * 100 + 7);
        end
        m_owner = -1; m_age = 0; m_turn = 0;
        for (int p = 0; p < 2; p++) begin m_rv[p] = 1'b0; m_rd[p] = '0; end
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            v[p] = 1'b1; w[p] = 1'b1; l[p] = 1'b0; a[p] = W'(p + 1); d[p] = 64'hdead;
        end
        @(posedge clk);

        // Reset held with both requesters valid
        for (int k = 0; k < 2; k++) begin
            begin_cycle();
            rst = 1'b1;
            set_req(0, 1'b1, 1'b1, 1'b0, 64'd1, 64'd11);
            set_req(1, 1'b1, 1'b1, 1'b0, 64'd2, 64'd22);
            eval();
            chk("rst_ready0", req_ready0, 64'd0);
            chk("rst_ready1", req_ready1, 64'd0);
            chk("rst_wen", mem_write_en, 64'd0);
            chk("rst_rv0", resp_valid0, 64'd0);
            chk("rst_rd1", resp_rdata1, 64'd0);
        end

        // Single port write then read back
        begin_cycle();
        set_req(0, 1'b1, 1'b1, 1'b0, 64'd3, 64'd54);
        eval();
        chk("sp_wr_ready0", req_ready0, 64'd1);
        chk("sp_wr_addr", mem_addr, 64'd3);
        chk("sp_wr_data", mem_data_input, 64'd54);
        begin_cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 64'd3, 64'd0);
        eval();
        chk("sp_rd_wen", mem_write_en, 64'd0);
        begin_cycle();
        eval();
        chk("sp_rv0", resp_valid0, 64'd1);
        chk("sp_rd0", resp_rdata0, 64'd54);
        chk("sp_rv1", resp_valid1, 64'd0);
        begin_cycle();
        eval();
        chk("sp_rv0_pulse", resp_valid0, 64'd0);

        // Contention: ptr points at port1 after port0's last grant
        for (int k = 0; k < 4; k++) begin
            begin_cycle();
            set_req(0, 1'b1, 1'b0, 1'b0, 64'd3, 64'd0);
            set_req(1, 1'b1, 1'b0, 1'b0, 64'd5, 64'd0);
            eval();
            chk("cont_ready0", req_ready0, W'(k % 2 == 1));
        end

        // Locked read-modify-write by port1 while port0 waits
        begin_cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 64'd3, 64'd0);
        set_req(1, 1'b1, 1'b0, 1'b1, 64'd5, 64'd0);
        eval();
        chk("rmw_rd_ready1", req_ready1, 64'd1);
        chk("rmw_rd_ready0", req_ready0, 64'd0);
        begin_cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 64'd3, 64'd0);
        set_req(1, 1'b1, 1'b1, 1'b0, 64'd5, 64'd13);
        eval();
        chk("rmw_wr_ready1", req_ready1, 64'd1);
        chk("rmw_wr_ready0", req_ready0, 64'd0);
        chk("rmw_old_data", resp_rdata1, 64'd507);
        begin_cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 64'd3, 64'd0);
        eval();
        chk("rmw_after_ready0", req_ready0, 64'd1);
        begin_cycle();
        set_req(0, 1'b1, 1'b0, 1'b0, 64'd5, 64'd0);
        eval();
        begin_cycle();
        eval();
        chk("rmw_readback", resp_rdata0, 64'd13);

        // Lock timeout: port1 holds lock, port0 always valid
        for (int k = 0; k < 6; k++) begin
            begin_cycle();
            set_req(0, 1'b1, 1'b0, 1'b0, 64'd2, 64'd0);
            set_req(1, 1'b1, 1'b0, 1'b1, W'(k), 64'd0);
            eval();
            if (k < 4) chk("to_hold_ready1", req_ready1, 64'd1);
            if (k == 4) chk("to_bubble", {req_ready0, req_ready1}, 64'd0);
            if (k == 5) chk("to_port0_next", {req_ready0, req_ready1}, 64'd2);
        end

        // Reset while port0 holds a lock with a read outstanding
        begin_cycle();
        set_req(0, 1'b1, 1'b0, 1'b1, 64'd7, 64'd0);
        eval();
        chk("ml_ready0", req_ready0, 64'd1);
        begin_cycle();
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b1, 64'd7, 64'd0);
        set_req(1, 1'b1, 1'b0, 1'b0, 64'd8, 64'd0);
        eval();
        chk("ml_rst_ready", {req_ready0, req_ready1}, 64'd0);
        begin_cycle();
        set_req(1, 1'b1, 1'b0, 1'b0, 64'd8, 64'd0);
        eval();
        chk("ml_rv0_dropped", resp_valid0, 64'd0);
        chk("ml_ready1", req_ready1, 64'd1);

        // Randomized traffic, occasional resets
        for (int k = 0; k < 3000; k++) begin
            begin_cycle();
            rst = ($urandom_range(199) == 0);
            for (int p = 0; p < 2; p++)
                set_req(p, $urandom_range(9) < 7, $urandom_range(1) == 1, $urandom_range(9) < 3,
                        W'($urandom_range(15)), {$urandom, $urandom});
            eval();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
